// File: rtl/frame_update_sequencer_pkg.sv
// Shared state encoding and phase indices for the frame update sequencer.
package pong_seq_pkg;

  localparam int NUM_PHASES = 4;
  localparam int PH_PADDLE  = 0;
  localparam int PH_BALL    = 1;
  localparam int PH_COLLIDE = 2;
  localparam int PH_SCORE   = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PADDLE  = 3'd1,
    BALL    = 3'd2,
    COLLIDE = 3'd3,
    SCORE   = 3'd4
  } seq_state_e;

  // Start strobe pattern presented on the first cycle of a phase state.
  function automatic logic [NUM_PHASES-1:0] phase_onehot(input seq_state_e s);
    logic [NUM_PHASES-1:0] oh;
    oh = '0;
    case (s)
      PADDLE:  oh[PH_PADDLE]  = 1'b1;
      BALL:    oh[PH_BALL]    = 1'b1;
      COLLIDE: oh[PH_COLLIDE] = 1'b1;
      SCORE:   oh[PH_SCORE]   = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/frame_update_sequencer_rise_edge_pulse.sv
// Registered rising-edge detector; RST_VAL preloads the previous sample so a
// signal already high at reset release does not produce a pulse.
module rise_edge_pulse #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      prev  <= RST_VAL;
      pulse <= 1'b0;
    end else begin
      prev  <= sig;
      pulse <= sig & ~prev;
    end
  end

endmodule

// File: rtl/frame_update_sequencer.sv
// Per-frame game update scheduler: paddle -> ball -> collide -> score.
// Optional per-phase watchdog enabled by defining SEQ_WATCHDOG_EN.
module frame_update_sequencer
  import pong_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int OVR_W          = 8,
  parameter int FRM_W          = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  frame_clk_in,
  input  logic                  enable,
  input  logic [NUM_PHASES-1:0] phase_done,
  output logic [NUM_PHASES-1:0] phase_start,
  output logic                  frame_pulse,
  output logic                  busy,
  output logic [OVR_W-1:0]      overrun_cnt,
  output logic [FRM_W-1:0]      frame_count,
  output logic                  timeout_flag
);

  seq_state_e state;
  seq_state_e adv_state;
  logic       cur_done;
  logic       wd_expire;

  rise_edge_pulse #(.RST_VAL(1'b1)) u_frame_edge (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig    (frame_clk_in),
    .pulse  (frame_pulse)
  );

  assign busy = (state != IDLE);

  // Only the done bit of the active phase matters.
  always_comb begin
    cur_done  = 1'b0;
    adv_state = IDLE;
    case (state)
      PADDLE:  begin cur_done = phase_done[PH_PADDLE];  adv_state = BALL;    end
      BALL:    begin cur_done = phase_done[PH_BALL];    adv_state = COLLIDE; end
      COLLIDE: begin cur_done = phase_done[PH_COLLIDE]; adv_state = SCORE;   end
      SCORE:   begin cur_done = phase_done[PH_SCORE];   adv_state = IDLE;    end
      default: begin cur_done = 1'b0;                   adv_state = IDLE;    end
    endcase
  end

`ifdef SEQ_WATCHDOG_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WAIT_W-1:0] wait_cnt;
  assign wd_expire = busy && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire    = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_start <= '0;
      overrun_cnt <= '0;
      frame_count <= '0;
`ifdef SEQ_WATCHDOG_EN
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      phase_start <= '0;
      // A frame landing on the SCORE->IDLE cycle still sees busy and is dropped.
      if (frame_pulse && busy && (overrun_cnt != {OVR_W{1'b1}}))
        overrun_cnt <= overrun_cnt + 1'b1;
`ifdef SEQ_WATCHDOG_EN
      if (busy) wait_cnt <= wait_cnt + 1'b1;
`endif
      if (state == IDLE) begin
        if (frame_pulse && enable) begin
          state       <= PADDLE;
          phase_start <= phase_onehot(PADDLE);
`ifdef SEQ_WATCHDOG_EN
          wait_cnt    <= '0;
`endif
        end
      end else if (cur_done) begin
        state       <= adv_state;
        phase_start <= phase_onehot(adv_state);
        if (state == SCORE) frame_count <= frame_count + 1'b1;
`ifdef SEQ_WATCHDOG_EN
        wait_cnt    <= '0;
`endif
      end else if (wd_expire) begin
        state <= IDLE;
`ifdef SEQ_WATCHDOG_EN
        wait_cnt     <= '0;
        timeout_flag <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_frame_update_sequencer.sv
// Scoreboard bench for frame_update_sequencer: expected pulses/starts queued at
// stimulus time, popped when the DUT emits them.
module tb_frame_update_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        frame_clk_in, enable;
  logic [3:0]  phase_done, phase_start;
  logic        frame_pulse, busy, timeout_flag;
  logic [7:0]  overrun_cnt;
  logic [15:0] frame_count;

  logic        wd_frame, wd_fp, wd_busy, wd_tmo;
  logic [3:0]  wd_done, wd_ps;
  logic [7:0]  wd_ovr;
  logic [15:0] wd_cnt;

  logic [3:0]  done_r, stray, done_tie;
  bit          resp_mode;
  int          dly[4];
  bit          pend[4];
  int          wcnt[4];

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  int ovr_exp = 0;
  int cnt_exp = 0;
  int t0;

  typedef struct {int cyc; logic [3:0] ps;} ps_ev_t;
  ps_ev_t ps_q[$];
  int     fp_q[$];

  assign phase_done = resp_mode ? (done_r | stray) : done_tie;

  frame_update_sequencer dut (
    .clk_in(clk_in), .rst_n(rst_n), .frame_clk_in(frame_clk_in), .enable(enable),
    .phase_done(phase_done), .phase_start(phase_start), .frame_pulse(frame_pulse),
    .busy(busy), .overrun_cnt(overrun_cnt), .frame_count(frame_count),
    .timeout_flag(timeout_flag)
  );

  frame_update_sequencer #(.TIMEOUT_CYCLES(16)) dut_wd (
    .clk_in(clk_in), .rst_n(rst_n), .frame_clk_in(wd_frame), .enable(1'b1),
    .phase_done(wd_done), .phase_start(wd_ps), .frame_pulse(wd_fp),
    .busy(wd_busy), .overrun_cnt(wd_ovr), .frame_count(wd_cnt),
    .timeout_flag(wd_tmo)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic push_ps(input int c, input logic [3:0] v);
    ps_ev_t ev;
    ev.cyc = c;
    ev.ps  = v;
    ps_q.push_back(ev);
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > 255) ? 255 : a + b;
  endfunction

  // Monitor: every strobe the DUT emits must match the head of its queue.
  always @(negedge clk_in) begin
    if (rst_n) begin
      if (phase_start != 4'b0) begin
        if (ps_q.size() == 0) chk("ps_extra", phase_start, 0);
        else begin
          ps_ev_t ev;
          ev = ps_q.pop_front();
          chk("ps_val", phase_start, ev.ps);
          chk("ps_cyc", cyc, ev.cyc);
        end
      end
      if (frame_pulse) begin
        if (fp_q.size() == 0) chk("fp_extra", frame_pulse, 0);
        else chk("fp_cyc", cyc, fp_q.pop_front());
      end
    end
  end

  // Done responder: answers phase i with a one-cycle done dly[i] cycles after start.
  always @(negedge clk_in) begin
    if (resp_mode)
      for (int i = 0; i < 4; i++)
        if (phase_start[i]) begin
          pend[i] = 1'b1;
          wcnt[i] = dly[i] - 1;
        end
  end

  always @(posedge clk_in) begin
    #1;
    for (int j = 0; j < 4; j++) begin
      done_r[j] = 1'b0;
      if (resp_mode && pend[j]) begin
        if (wcnt[j] == 0) begin
          done_r[j] = 1'b1;
          pend[j]   = 1'b0;
        end else wcnt[j]--;
      end
    end
  end

  initial begin
    rst_n = 1'b0; frame_clk_in = 1'b1; enable = 1'b1;
    done_tie = 4'h0; resp_mode = 1'b0; stray = 4'h0; done_r = 4'h0;
    wd_frame = 1'b0; wd_done = 4'h0;
    for (int i = 0; i < 4; i++) begin dly[i] = 1; pend[i] = 1'b0; wcnt[i] = 0; end

    // Reset with divider already high: outputs zero, no pulse after release.
    tick(3);
    chk("rst_ps", phase_start, 0);
    chk("rst_fp", frame_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_cnt", frame_count, 0);
    chk("rst_tmo", timeout_flag, 0);
    rst_n = 1'b1;
    tick(5);
    chk("rls_busy", busy, 0);
    frame_clk_in = 1'b0;
    tick(2);

    // All done tied high: minimum-length sequence.
    done_tie = 4'hF;
    t0 = cyc;
    frame_clk_in = 1'b1;
    fp_q.push_back(t0 + 1);
    for (int i = 0; i < 4; i++) push_ps(t0 + 2 + i, 4'(1 << i));
    tick(5);
    chk("tie_busy_hi", busy, 1);
    frame_clk_in = 1'b0;
    tick(1);
    chk("tie_busy_lo", busy, 0);
    cnt_exp = 1;
    chk("tie_cnt", frame_count, cnt_exp);
    tick(4);

    // 3-cycle done delays with stray done bits on inactive phases.
    done_tie = 4'h0;
    for (int i = 0; i < 4; i++) dly[i] = 3;
    resp_mode = 1'b1;
    t0 = cyc;
    frame_clk_in = 1'b1;
    fp_q.push_back(t0 + 1);
    for (int i = 0; i < 4; i++) push_ps(t0 + 2 + 4 * i, 4'(1 << i));
    tick(2);
    stray = 4'b1110;
    tick(3);
    stray = 4'h0;
    frame_clk_in = 1'b0;
    tick(13);
    chk("dly_busy", busy, 0);
    cnt_exp++;
    chk("dly_cnt", frame_count, cnt_exp);
    tick(2);

    // Ball phase stalls 25 cycles while frames arrive every 10 cycles.
    dly[0] = 1; dly[1] = 25; dly[2] = 1; dly[3] = 1;
    t0 = cyc;
    push_ps(t0 + 2, 4'b0001);
    push_ps(t0 + 4, 4'b0010);
    push_ps(t0 + 30, 4'b0100);
    push_ps(t0 + 32, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      fp_q.push_back(cyc + 1);
      frame_clk_in = 1'b1;
      tick(5);
      frame_clk_in = 1'b0;
      tick(5);
    end
    tick(4);
    chk("ovr_busy", busy, 0);
    ovr_exp = sat_add(ovr_exp, 2);
    cnt_exp++;
    chk("ovr_cnt2", overrun_cnt, ovr_exp);
    chk("ovr_frames", frame_count, cnt_exp);

    // enable dropped during BALL: sequence completes, next frame ignored.
    for (int i = 0; i < 4; i++) dly[i] = 1;
    t0 = cyc;
    frame_clk_in = 1'b1;
    fp_q.push_back(t0 + 1);
    for (int i = 0; i < 4; i++) push_ps(t0 + 2 + 2 * i, 4'(1 << i));
    tick(5);
    enable = 1'b0;
    frame_clk_in = 1'b0;
    tick(5);
    chk("en_busy", busy, 0);
    cnt_exp++;
    chk("en_cnt", frame_count, cnt_exp);
    tick(2);
    frame_clk_in = 1'b1;
    fp_q.push_back(cyc + 1);
    tick(5);
    frame_clk_in = 1'b0;
    tick(5);
    chk("en_idle", busy, 0);
    chk("en_ovr", overrun_cnt, ovr_exp);
    chk("en_cnt2", frame_count, cnt_exp);
    enable = 1'b1;

    // Saturation: hold PADDLE while frames arrive every 2 cycles.
    resp_mode = 1'b0;
    done_tie = 4'h0;
    t0 = cyc;
    push_ps(t0 + 2, 4'b0001);
    for (int k = 0; k < 302; k++) begin
      fp_q.push_back(cyc + 1);
      frame_clk_in = 1'b1;
      tick(1);
      frame_clk_in = 1'b0;
      tick(1);
    end
    ovr_exp = sat_add(ovr_exp, 301);
    chk("sat_ovr", overrun_cnt, ovr_exp);
    chk("sat_busy", busy, 1);
    t0 = cyc;
    done_tie = 4'hF;
    for (int i = 1; i < 4; i++) push_ps(t0 + i, 4'(1 << i));
    tick(4);
    chk("sat_idle", busy, 0);
    cnt_exp++;
    chk("sat_cnt", frame_count, cnt_exp);
    chk("sat_hold", overrun_cnt, ovr_exp);

    // Reset mid-sequence.
    done_tie = 4'h0;
    t0 = cyc;
    frame_clk_in = 1'b1;
    fp_q.push_back(t0 + 1);
    push_ps(t0 + 2, 4'b0001);
    tick(4);
    chk("mid_busy_pre", busy, 1);
    frame_clk_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_ovr", overrun_cnt, 0);
    chk("mid_cnt", frame_count, 0);
    chk("mid_ps", phase_start, 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("mid_idle", busy, 0);

    // Watchdog instance (TIMEOUT_CYCLES=16, done never arrives).
    t0 = cyc;
    wd_frame = 1'b1;
    tick(2);
    wd_frame = 1'b0;
    chk("wd_start", wd_ps, 4'b0001);
`ifdef SEQ_WATCHDOG_EN
    tick(15);
    chk("wd_last", wd_busy, 1);
    tick(1);
    chk("wd_abort", wd_busy, 0);
    chk("wd_tmo", wd_tmo, 1);
    chk("wd_cnt", wd_cnt, 0);
    tick(10);
    chk("wd_sticky", wd_tmo, 1);
    // done on the timeout cycle takes priority over the abort
    wd_frame = 1'b1;
    tick(2);
    wd_frame = 1'b0;
    chk("wd_start2", wd_ps, 4'b0001);
    tick(15);
    wd_done = 4'b0001;
    tick(1);
    wd_done = 4'b0000;
    chk("wd_win", wd_ps, 4'b0010);
    tick(16);
    chk("wd_abort2", wd_busy, 0);
    chk("wd_cnt2", wd_cnt, 0);
`else
    tick(1000);
    chk("wd_hold", wd_busy, 1);
    chk("wd_notmo", wd_tmo, 0);
`endif
    chk("main_tmo", timeout_flag, 0);

    chk("ps_q_left", ps_q.size(), 0);
    chk("fp_q_left", fp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_update_sequencer.md
Name: frame_update_sequencer

Overview:
- Game-logic scheduler driven by the frame divider's slow square-wave output (same clk_in domain, counter-derived).
- On each frame rising edge, it runs four update phases in a fixed order: paddle, ball, collision, score. Each phase uses a start/done handshake with its owning block.
- Frames that arrive mid-sequence are dropped and counted. Completed sequences are counted.
- Sits between the frame divider and the game-state update blocks, ahead of the VGA draw logic.

Parameters:
- TIMEOUT_CYCLES, 4096, max cycles a phase may wait for done (used only with SEQ_WATCHDOG_EN).
- OVR_W, 8, width of the overrun counter.
- FRM_W, 16, width of the completed-frame counter.

Ports:
- clk_in  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- frame_clk_in  input  1  frame divider output, synchronous to clk_in.
- enable  input  1  allow new sequences to start.
- phase_done  input  4  per-phase completion; bit0 paddle, bit1 ball, bit2 collide, bit3 score.
- phase_start  output  4  one-hot, one-cycle start strobe per phase.
- frame_pulse  output  1  one-cycle strobe on each detected frame rising edge.
- busy  output  1  high while a sequence is in progress.
- overrun_cnt  output  OVR_W  dropped-frame count, saturating.
- frame_count  output  FRM_W  completed sequences, wrapping.
- timeout_flag  output  1  sticky phase-timeout indicator.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - prev_frame register is set to 1.
  - All outputs go to 0.
- Edge detect:
  - frame_pulse = frame_clk_in & ~prev_frame, registered.
  - It asserts the cycle after frame_clk_in is first sampled high.
  - The prev_frame reset value of 1 suppresses a spurious pulse when the divider is already high at reset release.
- FSM states: IDLE, PADDLE, BALL, COLLIDE, SCORE.
- IDLE transitions:
  - frame_pulse & enable → PADDLE.
  - frame_pulse & ~enable → stay in IDLE; no count.
- Phase states:
  - phase_start[i] is high exactly on the first cycle in state i. It is registered, aligned with the state register.
  - phase_done[i] is sampled from the first cycle onward. When sampled high, the FSM advances next cycle; done coincident with start is legal.
  - Transitions: PADDLE → BALL → COLLIDE → SCORE → IDLE.
  - Done bits of inactive phases are ignored.
- Latency:
  - Frame edge to phase_start[0]: 2 cycles (1 for the pulse, 1 for the state).
  - Minimum sequence with all done tied high: 4 cycles in phase states.
- busy = (state != IDLE).
- frame_count increments by 1 on the SCORE→IDLE transition and wraps at 2^FRM_W.
- Overrun:
  - frame_pulse while busy: the frame is dropped (not queued) and overrun_cnt increments, saturating at 2^OVR_W-1.
  - frame_pulse on the same cycle as SCORE→IDLE is treated as busy and counted as an overrun.
- enable deasserted mid-sequence: the current sequence completes normally; no new sequence starts.
- Reset mid-sequence: immediate return to IDLE. No phase_start is issued. Counters clear.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- With the macro defined:
  - A per-phase wait counter (clog2(TIMEOUT_CYCLES)+1 bits) clears on every state entry and increments while in a phase state.
  - If it reaches TIMEOUT_CYCLES-1 without done, the FSM aborts to IDLE. timeout_flag sets and stays set until reset. frame_count does not increment.
  - done arriving on the timeout cycle wins; the FSM advances normally.
- Without the macro:
  - Phases wait indefinitely.
  - timeout_flag is tied to 0.
  - No counter logic is synthesized.

Decomposition:
- Package pong_seq_pkg holds:
  - State encoding constants: IDLE=3'd0, PADDLE=3'd1, BALL=3'd2, COLLIDE=3'd3, SCORE=3'd4.
  - Phase index constants: PH_PADDLE=0, PH_BALL=1, PH_COLLIDE=2, PH_SCORE=3.
  - NUM_PHASES=4.
- Sub-module: rise_edge_pulse, a registered rising-edge detector with configurable reset value for the previous-sample register; it produces frame_pulse.

Test Plan:
- Reset release with frame_clk_in=1 → no frame_pulse; first pulse only after a 0→1 transition. All outputs 0 during reset.
- phase_done tied 4'b1111, enable=1, single frame edge:
  - frame_pulse at T+1.
  - phase_start = 0001, 0010, 0100, 1000 on T+2..T+5.
  - busy low at T+6.
  - frame_count = 1.
- Per-phase done delays of 3 cycles: each phase_start is 1 cycle wide; next start exactly 1 cycle after the done sample. Stray done on an inactive phase is ignored.
- Frame edges every 10 cycles while phase 1 done is held low for 25 cycles:
  - overrun_cnt increments 2 times.
  - No extra phase_start.
  - After 300 forced overruns, overrun_cnt holds at 255.
- enable dropped during BALL → sequence completes, frame_count increments. The next frame edge produces frame_pulse but no phase_start and no overrun.
- SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=16, phase_done=0 → abort to IDLE after 16 cycles in PADDLE; timeout_flag=1 and sticky; frame_count unchanged. Without the macro, the FSM stays in PADDLE for 1000 cycles.
